cpu_sequencer: RTL and testbench
================================

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter: WAIT_LIMIT, default 15, max consecutive cycles waiting on mem_ready before a fault; legal range 1..255.
REQ-002 Port: clk  input  1  single system clock; all state changes on the rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: run  input  1  permits instruction execution; sampled in IDLE and at each instruction boundary.
REQ-005 Port: instruction  input  16  current IR contents, used for instruction-class decode.
REQ-006 Port: ram_read / ram_write  input  1 each  memory-access flags from the instruction decoder.
REQ-007 Port: mem_ready  input  1  memory completes the current request this cycle.
REQ-008 Port: mem_req / mem_we  output  1 each  memory request and write enable.
REQ-009 Port: addr_sel  output  1  memory address source: 0 = PC, 1 = ALU result.
REQ-010 Port: ir_load / pc_write / pc_inc / reg_write / wb_sel / cond_write  output  1 each  one-cycle strobes; wb_sel selects write-back source (0 = ALU, 1 = memory data).
REQ-011 Port: busy / fault  output  1 each  not-IDLE indicator; sticky wait-timeout fault.
REQ-012 Port: state  output  3  current FSM state encoding.

Function
REQ-013 States SHALL be IDLE, FETCH, DECODE, EXEC, MEM, FAULT; IDLE -> FETCH when run=1.
REQ-014 FETCH SHALL drive mem_req=1, addr_sel=0, mem_we=0; on mem_ready it SHALL pulse ir_load in that cycle and go to DECODE.
REQ-015 DECODE SHALL last exactly one cycle with all strobes 0, then go to EXEC.
REQ-016 Classes: branch = instruction[15]=1; load/store = [15:14]=01; ALU = [15:11] in {00000, 00001} or [15:13]=001; all others are no-op.
REQ-017 EXEC, branch: pc_write=1 for one cycle; pc_inc=0; then boundary.
REQ-018 EXEC, ALU: reg_write=1, wb_sel=0, cond_write=1, pc_inc=1 for one cycle; then boundary.
REQ-019 EXEC, no-op: pc_inc=1 only; then boundary.
REQ-020 EXEC, load/store (ram_read or ram_write = 1): no strobes; go to MEM.
REQ-021 MEM SHALL drive mem_req=1, addr_sel=1, mem_we=ram_write; on mem_ready it SHALL pulse pc_inc, plus reg_write=1 and wb_sel=1 when ram_read=1; then boundary.
REQ-022 Boundary: next state = FETCH if run=1, else IDLE; deasserting run SHALL never abort an instruction in progress.
REQ-023 Fetch-to-fetch latency SHALL be 3 cycles (ALU, branch, no-op) and 4 cycles (load/store), given zero-wait memory.
REQ-024 Wait counter (8 bit) SHALL increment each FETCH/MEM cycle with mem_req=1 and mem_ready=0, and clear on mem_ready or on state change.
REQ-025 On a cycle where mem_ready=0 and the counter equals WAIT_LIMIT-1, the FSM SHALL go to FAULT.
REQ-026 If mem_ready=1 in the same cycle the limit would be reached, ready SHALL win and no fault occurs.
REQ-027 FAULT: fault=1, mem_req=0, all strobes 0; FAULT SHALL be left only by reset.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 At most one of pc_write and pc_inc SHALL be asserted in any cycle.

Reset
REQ-030 Reset SHALL asynchronously force IDLE, clear the wait counter and fault, and drive all outputs to 0, including mid-request (mem_req drops without waiting for mem_ready).
REQ-031 The first FETCH after reset release SHALL occur no earlier than the first clock edge with run=1.

Configuration
REQ-032 With CPU_SEQ_RETIRE_COUNT_EN defined: 16-bit output retired_count, reset to 0, increments by 1 at each completed instruction boundary and wraps 0xFFFF -> 0x0000; not incremented on FAULT.
REQ-033 Without CPU_SEQ_RETIRE_COUNT_EN: port and counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-034 A shared package SHALL hold the state encoding (IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, FAULT=7), the instruction-class prefix constants, and the wb_sel / addr_sel encodings.
REQ-035 The wait counter and limit compare SHALL be a sub-module seq_wait_timer (inputs: enable, clear; output: expired).

Verification
REQ-036 run=1, zero-wait memory, instruction 0x0A0B (ALU): ir_load@t, EXEC@t+2 with reg_write=cond_write=pc_inc=1, next mem_req@t+3.
REQ-037 Instruction 0x4085 with ram_read=1: MEM cycle shows addr_sel=1, mem_we=0; on mem_ready, reg_write=1, wb_sel=1, pc_inc=1.
REQ-038 Instruction 0x8FFE (branch): pc_write=1 exactly once, pc_inc=0, no reg_write.
REQ-039 WAIT_LIMIT=4, mem_ready held 0 in FETCH: fault=1 on the 5th edge after FETCH entry, mem_req=0 thereafter; mem_ready=1 on the 4th wait cycle instead yields no fault.
REQ-040 run dropped during MEM with 2 wait states: store completes, then IDLE with busy=0; reset asserted mid-FETCH drops mem_req immediately, without a clock edge.
REQ-041 With CPU_SEQ_RETIRE_COUNT_EN defined and preloaded at 0xFFFF: one more instruction wraps retired_count to 0x0000.

Source files
------------

// File: rtl/cpu_sequencer_pkg.sv
// cpu_sequencer_pkg
// Holds the types and constants shared by the CPU sequencer files:
//   - seq_state_t   : FSM state encoding (also the value driven on the state port)
//   - instr_class_t : instruction classes recognised by the sequencer
//   - class prefixes: upper-opcode patterns that select a class
//   - address / write-back source encodings
//   - decode_class(): maps instruction[15:11] to a class
package cpu_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_FAULT  = 3'd7
    } seq_state_t;

    typedef enum logic [1:0] {
        CLS_NOP,
        CLS_ALU,
        CLS_LS,
        CLS_BRANCH
    } instr_class_t;

    // Prefixes are matched against the top of the opcode, instruction[15:11].
    localparam logic       BRANCH_PREFIX = 1'b1;     // [15]
    localparam logic [1:0] LS_PREFIX     = 2'b01;    // [15:14]
    localparam logic [3:0] ALU_PREFIX_A  = 4'b0000;  // [15:12] -> opcodes 00000 and 00001
    localparam logic [2:0] ALU_PREFIX_B  = 3'b001;   // [15:13]

    localparam logic ADDR_SEL_PC  = 1'b0;
    localparam logic ADDR_SEL_ALU = 1'b1;
    localparam logic WB_SEL_ALU   = 1'b0;
    localparam logic WB_SEL_MEM   = 1'b1;

    localparam int WAIT_CNT_W = 8;

    // Branch is checked first because its single-bit prefix overlaps nothing
    // else; load/store next; the ALU prefixes only live in the 00x range.
    function automatic instr_class_t decode_class(input logic [4:0] opcode);
        instr_class_t cls;
        if (opcode[4] == BRANCH_PREFIX) begin
            cls = CLS_BRANCH;
        end else if (opcode[4:3] == LS_PREFIX) begin
            cls = CLS_LS;
        end else if (opcode[4:1] == ALU_PREFIX_A || opcode[4:2] == ALU_PREFIX_B) begin
            cls = CLS_ALU;
        end else begin
            cls = CLS_NOP;
        end
        return cls;
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if
// Bundles the sequencer's control inputs and its memory/datapath strobes.
//   master : the sequencer (drives requests, strobes, status)
//   slave  : the datapath / memory side (drives run, IR, decode flags, mem_ready)
// Signals:
//   run, instruction[15:0], ram_read, ram_write, mem_ready   (slave -> master)
//   mem_req, mem_we, addr_sel, ir_load, pc_write, pc_inc,
//   reg_write, wb_sel, cond_write, busy, fault, state[2:0]    (master -> slave)
interface cpu_sequencer_if;
    import cpu_sequencer_pkg::*;

    logic        run;
    logic [15:0] instruction;
    logic        ram_read;
    logic        ram_write;
    logic        mem_ready;

    logic        mem_req;
    logic        mem_we;
    logic        addr_sel;
    logic        ir_load;
    logic        pc_write;
    logic        pc_inc;
    logic        reg_write;
    logic        wb_sel;
    logic        cond_write;
    logic        busy;
    logic        fault;
    seq_state_t  state;

    modport master (
        input  run, instruction, ram_read, ram_write, mem_ready,
        output mem_req, mem_we, addr_sel, ir_load, pc_write, pc_inc,
               reg_write, wb_sel, cond_write, busy, fault, state
    );

    modport slave (
        output run, instruction, ram_read, ram_write, mem_ready,
        input  mem_req, mem_we, addr_sel, ir_load, pc_write, pc_inc,
               reg_write, wb_sel, cond_write, busy, fault, state
    );

endinterface

// File: rtl/seq_wait_timer.sv
// seq_wait_timer
// Counts consecutive cycles spent waiting on memory and flags the cycle on
// which the wait limit is reached.
// Parameters:
//   WAIT_LIMIT : number of waiting cycles tolerated (1..255)
// Ports:
//   clk     : system clock
//   reset   : asynchronous, active-high
//   enable  : a request is outstanding and memory is not ready this cycle
//   clear   : restart the count (memory answered or the FSM changes state)
//   expired : this waiting cycle is the last one allowed
module seq_wait_timer
    import cpu_sequencer_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam logic [WAIT_CNT_W-1:0] LAST_WAIT = WAIT_CNT_W'(WAIT_LIMIT - 1);

    logic [WAIT_CNT_W-1:0] count_q;

    // NOTE: registers are written with non-blocking assignments so every flop
    // in the design samples the values that existed before the clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + WAIT_CNT_W'(1);
        end
    end

    // enable already excludes mem_ready, so a ready on the final cycle wins.
    assign expired = enable && (count_q == LAST_WAIT);

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer
// Multi-cycle instruction sequencer: IDLE -> FETCH -> DECODE -> EXEC [-> MEM]
// -> FETCH/IDLE, with a sticky FAULT when memory stalls for too long.
// Parameters:
//   WAIT_LIMIT : consecutive mem_ready=0 cycles tolerated in FETCH/MEM (1..255)
// Ports:
//   clk           : system clock, all state changes on the rising edge
//   reset         : asynchronous, active-high; forces IDLE and all outputs low
//   bus           : cpu_sequencer_if.master (run/IR/decode flags in,
//                   memory request and datapath strobes out)
//   retired_count : 16-bit count of completed instructions (only when
//                   CPU_SEQ_RETIRE_COUNT_EN is defined)
// Configuration macro: CPU_SEQ_RETIRE_COUNT_EN
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic            clk,
    input  logic            reset,
    cpu_sequencer_if.master bus
`ifdef CPU_SEQ_RETIRE_COUNT_EN
    ,
    output logic [15:0]     retired_count
`endif
);

    seq_state_t   state_q;
    seq_state_t   state_next;
    instr_class_t cls;
    logic [4:0]   opcode;
    logic         unused_instr_bits;

    logic mem_req, mem_we, addr_sel, ir_load, pc_write, pc_inc;
    logic reg_write, wb_sel, cond_write, fault;
    logic boundary;
    logic wait_enable, wait_clear, wait_expired;

    assign opcode            = bus.instruction[15:11];
    assign unused_instr_bits = ^bus.instruction[10:0];
    assign cls               = decode_class(opcode);

    // Strobes answer mem_ready in the same cycle (ir_load with the fetch
    // data, pc_inc/reg_write with the load data), so they are decoded from
    // the registered state rather than registered themselves. Reset forces
    // the state to IDLE, which takes every output low without a clock edge.
    always_comb begin
        // NOTE: every output is given a default before the case so that no
        // path through it leaves a signal unassigned and infers a latch.
        state_next = state_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = ADDR_SEL_PC;
        ir_load    = 1'b0;
        pc_write   = 1'b0;
        pc_inc     = 1'b0;
        reg_write  = 1'b0;
        wb_sel     = WB_SEL_ALU;
        cond_write = 1'b0;
        fault      = 1'b0;
        boundary   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.run) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req  = 1'b1;
                addr_sel = ADDR_SEL_PC;
                if (bus.mem_ready) begin
                    ir_load    = 1'b1;
                    state_next = ST_DECODE;
                end else if (wait_expired) begin
                    state_next = ST_FAULT;
                end
            end
            ST_DECODE: begin
                state_next = ST_EXEC;
            end
            ST_EXEC: begin
                case (cls)
                    CLS_BRANCH: begin
                        pc_write = 1'b1;
                        boundary = 1'b1;
                    end
                    CLS_ALU: begin
                        reg_write  = 1'b1;
                        wb_sel     = WB_SEL_ALU;
                        cond_write = 1'b1;
                        pc_inc     = 1'b1;
                        boundary   = 1'b1;
                    end
                    CLS_LS: begin
                        // A load/store opcode without a memory flag has
                        // nothing to transfer and retires like a no-op.
                        if (bus.ram_read || bus.ram_write) begin
                            state_next = ST_MEM;
                        end else begin
                            pc_inc   = 1'b1;
                            boundary = 1'b1;
                        end
                    end
                    default: begin
                        pc_inc   = 1'b1;
                        boundary = 1'b1;
                    end
                endcase
            end
            ST_MEM: begin
                mem_req  = 1'b1;
                addr_sel = ADDR_SEL_ALU;
                mem_we   = bus.ram_write;
                if (bus.mem_ready) begin
                    pc_inc   = 1'b1;
                    boundary = 1'b1;
                    if (bus.ram_read) begin
                        reg_write = 1'b1;
                        wb_sel    = WB_SEL_MEM;
                    end
                end else if (wait_expired) begin
                    state_next = ST_FAULT;
                end
            end
            ST_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // run is only consulted once the instruction has fully retired.
        if (boundary) state_next = bus.run ? ST_FETCH : ST_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_next;
    end

    assign wait_enable = (state_q == ST_FETCH || state_q == ST_MEM) && !bus.mem_ready;
    assign wait_clear  = bus.mem_ready || (state_next != state_q);

    seq_wait_timer #(
        .WAIT_LIMIT(WAIT_LIMIT)
    ) u_wait_timer (
        .clk    (clk),
        .reset  (reset),
        .enable (wait_enable),
        .clear  (wait_clear),
        .expired(wait_expired)
    );

`ifdef CPU_SEQ_RETIRE_COUNT_EN
    logic [15:0] retire_q;

    // Wraps naturally at 16 bits; FAULT never asserts boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         retire_q <= '0;
        else if (boundary) retire_q <= retire_q + 16'd1;
    end

    assign retired_count = retire_q;
`endif

    assign bus.mem_req    = mem_req;
    assign bus.mem_we     = mem_we;
    assign bus.addr_sel   = addr_sel;
    assign bus.ir_load    = ir_load;
    assign bus.pc_write   = pc_write;
    assign bus.pc_inc     = pc_inc;
    assign bus.reg_write  = reg_write;
    assign bus.wb_sel     = wb_sel;
    assign bus.cond_write = cond_write;
    assign bus.fault      = fault;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.state      = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer
// Directed bench for cpu_sequencer. Each step drives one cycle of inputs just
// after the rising edge and pushes the hand-derived outputs for that cycle
// into a scoreboard queue; a monitor on the falling edge pops and compares.
module tb_cpu_sequencer;
    import cpu_sequencer_pkg::*;

    localparam int unsigned WAIT_LIMIT = 4;

    logic clk = 1'b0;
    logic reset;

    cpu_sequencer_if bus_if ();

`ifdef CPU_SEQ_RETIRE_COUNT_EN
    logic [15:0] retired_count;
`endif

    cpu_sequencer #(
        .WAIT_LIMIT(WAIT_LIMIT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
`ifdef CPU_SEQ_RETIRE_COUNT_EN
        ,
        .retired_count(retired_count)
`endif
    );

    always #5 clk = ~clk;

    // Observed output vector, printed as one binary word in this field order.
    typedef struct packed {
        logic [2:0] state;
        logic       busy;
        logic       fault;
        logic       mem_req;
        logic       mem_we;
        logic       addr_sel;
        logic       ir_load;
        logic       pc_write;
        logic       pc_inc;
        logic       reg_write;
        logic       wb_sel;
        logic       cond_write;
    } obs_t;

    typedef struct {
        string       name;
        obs_t        exp;
        logic        chk_retire;
        logic [15:0] exp_retire;
    } vec_t;

    vec_t sb[$];
    int   n_vectors     = 0;
    int   n_miscompares = 0;

    // ---------------- expected-output constructors ----------------
    function automatic obs_t o_idle();
        obs_t o = '0;
        return o;
    endfunction

    function automatic obs_t o_fetch(input logic rdy);
        obs_t o = '0;
        o.state = ST_FETCH; o.busy = 1'b1; o.mem_req = 1'b1; o.ir_load = rdy;
        return o;
    endfunction

    function automatic obs_t o_decode();
        obs_t o = '0;
        o.state = ST_DECODE; o.busy = 1'b1;
        return o;
    endfunction

    function automatic obs_t o_exec_alu();
        obs_t o = '0;
        o.state = ST_EXEC; o.busy = 1'b1;
        o.reg_write = 1'b1; o.cond_write = 1'b1; o.pc_inc = 1'b1;
        return o;
    endfunction

    function automatic obs_t o_exec_br();
        obs_t o = '0;
        o.state = ST_EXEC; o.busy = 1'b1; o.pc_write = 1'b1;
        return o;
    endfunction

    function automatic obs_t o_exec_nop();
        obs_t o = '0;
        o.state = ST_EXEC; o.busy = 1'b1; o.pc_inc = 1'b1;
        return o;
    endfunction

    function automatic obs_t o_exec_ls();
        obs_t o = '0;
        o.state = ST_EXEC; o.busy = 1'b1;
        return o;
    endfunction

    function automatic obs_t o_mem(input logic wr, input logic rdy);
        obs_t o = '0;
        o.state = ST_MEM; o.busy = 1'b1; o.mem_req = 1'b1;
        o.addr_sel = 1'b1; o.mem_we = wr;
        if (rdy) begin
            o.pc_inc = 1'b1;
            if (!wr) begin
                o.reg_write = 1'b1;
                o.wb_sel    = 1'b1;
            end
        end
        return o;
    endfunction

    function automatic obs_t o_fault();
        obs_t o = '0;
        o.state = ST_FAULT; o.busy = 1'b1; o.fault = 1'b1;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.state      = bus_if.state;
        o.busy       = bus_if.busy;
        o.fault      = bus_if.fault;
        o.mem_req    = bus_if.mem_req;
        o.mem_we     = bus_if.mem_we;
        o.addr_sel   = bus_if.addr_sel;
        o.ir_load    = bus_if.ir_load;
        o.pc_write   = bus_if.pc_write;
        o.pc_inc     = bus_if.pc_inc;
        o.reg_write  = bus_if.reg_write;
        o.wb_sel     = bus_if.wb_sel;
        o.cond_write = bus_if.cond_write;
        return o;
    endfunction

    // ---------------- stimulus ----------------
    task automatic step(input string name, input logic rst, input logic run,
                        input logic [15:0] instr, input logic rr, input logic rw,
                        input logic rdy, input obs_t exp,
                        input logic chk_r = 1'b0, input logic [15:0] exp_r = 16'h0000);
        vec_t v;
        reset                 = rst;
        bus_if.run            = run;
        bus_if.instruction    = instr;
        bus_if.ram_read       = rr;
        bus_if.ram_write      = rw;
        bus_if.mem_ready      = rdy;
        v.name       = name;
        v.exp        = exp;
        v.chk_retire = chk_r;
        v.exp_retire = exp_r;
        sb.push_back(v);
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            vec_t v;
            obs_t act;
            v   = sb.pop_front();
            act = sample();
            n_vectors++;
            if (act !== v.exp) begin
                n_miscompares++;
                $display("FAIL %s: got %b, expected %b (state,busy,fault,mem_req,mem_we,addr_sel,ir_load,pc_write,pc_inc,reg_write,wb_sel,cond_write)",
                         v.name, act, v.exp);
            end
`ifdef CPU_SEQ_RETIRE_COUNT_EN
            if (v.chk_retire) begin
                n_vectors++;
                if (retired_count !== v.exp_retire) begin
                    n_miscompares++;
                    $display("FAIL %s retired_count: got %h, expected %h",
                             v.name, retired_count, v.exp_retire);
                end
            end
`endif
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset              = 1'b1;
        bus_if.run         = 1'b0;
        bus_if.instruction = 16'h0000;
        bus_if.ram_read    = 1'b0;
        bus_if.ram_write   = 1'b0;
        bus_if.mem_ready   = 1'b0;
        @(posedge clk);
        #1;

        // Reset holds IDLE even with run and mem_ready high; no fetch until run.
        step("reset_hold",  1, 1, 16'h0000, 0, 0, 1, o_idle());
        step("idle_run0_a", 0, 0, 16'h0000, 0, 0, 0, o_idle());
        step("idle_run0_b", 0, 0, 16'h0000, 0, 0, 0, o_idle());
        step("idle_run1",   0, 1, 16'h0A0B, 0, 0, 0, o_idle());

        // ALU 0x0A0B: ir_load@t, EXEC@t+2, next fetch@t+3.
        step("alu_fetch",   0, 1, 16'h0A0B, 0, 0, 1, o_fetch(1));
        step("alu_decode",  0, 1, 16'h0A0B, 0, 0, 0, o_decode());
        step("alu_exec",    0, 1, 16'h0A0B, 0, 0, 0, o_exec_alu());

        // No-op 0x1000 (opcode 00010).
        step("nop_fetch",   0, 1, 16'h1000, 0, 0, 1, o_fetch(1));
        step("nop_decode",  0, 1, 16'h1000, 0, 0, 0, o_decode());
        step("nop_exec",    0, 1, 16'h1000, 0, 0, 0, o_exec_nop());

        // Branch 0x8FFE: pc_write once, no pc_inc, no reg_write.
        step("br_fetch",    0, 1, 16'h8FFE, 0, 0, 1, o_fetch(1));
        step("br_decode",   0, 1, 16'h8FFE, 0, 0, 0, o_decode());
        step("br_exec",     0, 1, 16'h8FFE, 0, 0, 0, o_exec_br());

        // ALU through the 001 prefix.
        step("alu2_fetch",  0, 1, 16'h2345, 0, 0, 1, o_fetch(1));
        step("alu2_decode", 0, 1, 16'h2345, 0, 0, 0, o_decode());
        step("alu2_exec",   0, 1, 16'h2345, 0, 0, 0, o_exec_alu());

        // Load 0x4085: one fetch wait, one MEM wait.
        step("ld_fetch_w",  0, 1, 16'h4085, 1, 0, 0, o_fetch(0));
        step("ld_fetch",    0, 1, 16'h4085, 1, 0, 1, o_fetch(1));
        step("ld_decode",   0, 1, 16'h4085, 1, 0, 0, o_decode());
        step("ld_exec",     0, 1, 16'h4085, 1, 0, 0, o_exec_ls());
        step("ld_mem_w",    0, 1, 16'h4085, 1, 0, 0, o_mem(0, 0));
        step("ld_mem_done", 0, 1, 16'h4085, 1, 0, 1, o_mem(0, 1));

        // Store, run dropped during MEM with two wait states: completes, then IDLE.
        step("st_fetch",    0, 1, 16'h4001, 0, 1, 1, o_fetch(1));
        step("st_decode",   0, 1, 16'h4001, 0, 1, 0, o_decode());
        step("st_exec",     0, 1, 16'h4001, 0, 1, 0, o_exec_ls());
        step("st_mem_w1",   0, 0, 16'h4001, 0, 1, 0, o_mem(1, 0));
        step("st_mem_w2",   0, 0, 16'h4001, 0, 1, 0, o_mem(1, 0));
        step("st_mem_done", 0, 0, 16'h4001, 0, 1, 1, o_mem(1, 1));
        step("st_idle",     0, 0, 16'h0000, 0, 0, 0, o_idle());

        // run dropped during DECODE of an ALU op: still executes, then IDLE.
        step("drop_idle",   0, 1, 16'h0001, 0, 0, 0, o_idle());
        step("drop_fetch",  0, 1, 16'h0001, 0, 0, 1, o_fetch(1));
        step("drop_decode", 0, 0, 16'h0001, 0, 0, 0, o_decode());
        step("drop_exec",   0, 0, 16'h0001, 0, 0, 0, o_exec_alu());
        step("drop_after",  0, 0, 16'h0001, 0, 0, 0, o_idle());

        // Ready on the 4th wait cycle wins over the limit.
        step("rw_idle",     0, 1, 16'h1800, 0, 0, 0, o_idle());
        step("rw_wait1",    0, 1, 16'h1800, 0, 0, 0, o_fetch(0));
        step("rw_wait2",    0, 1, 16'h1800, 0, 0, 0, o_fetch(0));
        step("rw_wait3",    0, 1, 16'h1800, 0, 0, 0, o_fetch(0));
        step("rw_ready4",   0, 1, 16'h1800, 0, 0, 1, o_fetch(1));
        step("rw_decode",   0, 0, 16'h1800, 0, 0, 0, o_decode());
        step("rw_exec",     0, 0, 16'h1800, 0, 0, 0, o_exec_nop());
        step("rw_idle_end", 0, 0, 16'h1800, 0, 0, 0, o_idle());

        // Four waits without ready: FAULT on the 5th edge after FETCH entry.
        step("to_idle",     0, 1, 16'h0A0B, 0, 0, 0, o_idle());
        step("to_wait1",    0, 1, 16'h0A0B, 0, 0, 0, o_fetch(0));
        step("to_wait2",    0, 1, 16'h0A0B, 0, 0, 0, o_fetch(0));
        step("to_wait3",    0, 1, 16'h0A0B, 0, 0, 0, o_fetch(0));
        step("to_wait4",    0, 1, 16'h0A0B, 0, 0, 0, o_fetch(0));
        step("to_fault",    0, 1, 16'h0A0B, 0, 0, 1, o_fault());
        step("to_sticky",   0, 0, 16'h0A0B, 0, 0, 0, o_fault());

        // Reset leaves FAULT asynchronously; then reset mid-FETCH drops mem_req
        // before any clock edge.
        step("rst_fault",   1, 0, 16'h0000, 0, 0, 0, o_idle());
        step("rst_run",     0, 1, 16'h0000, 0, 0, 0, o_idle());
        step("rst_fetch",   0, 1, 16'h0000, 0, 0, 0, o_fetch(0));
        step("rst_mid",     1, 1, 16'h0000, 0, 0, 0, o_idle());
        step("rst_rel",     0, 0, 16'h0000, 0, 0, 0, o_idle());
        step("rst_quiet",   0, 0, 16'h0000, 0, 0, 0, o_idle());

`ifdef CPU_SEQ_RETIRE_COUNT_EN
        // Preload the count and retire one no-op: it wraps to zero.
        dut.retire_q = 16'hFFFF;
        step("rc_idle",     0, 1, 16'h1000, 0, 0, 0, o_idle(),     1, 16'hFFFF);
        step("rc_fetch",    0, 1, 16'h1000, 0, 0, 1, o_fetch(1),   1, 16'hFFFF);
        step("rc_decode",   0, 0, 16'h1000, 0, 0, 0, o_decode(),   1, 16'hFFFF);
        step("rc_exec",     0, 0, 16'h1000, 0, 0, 0, o_exec_nop(), 1, 16'hFFFF);
        step("rc_wrap",     0, 0, 16'h1000, 0, 0, 0, o_idle(),     1, 16'h0000);
`endif

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
